fifo_word_packer: RTL
=====================

# fifo_word_packer

Downstream consumer of the 8-deep, 8-bit FIFO: drives the FIFO's read enable, captures the registered byte and error flag one cycle later, and packs byte pairs into 16-bit words presented on a valid/ready output port. A flush input, and an optional idle timeout, emit a half-filled word with a partial marker so that a trailing odd byte is never stranded.

## Interface
- TIMEOUT, 16: consecutive empty reads (byte held) before auto-flush; range 1..255; used only with PACKER_TIMEOUT_EN.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- fifo_ren  out  1  read request to the FIFO; connects to its ren.
- fifo_dout  in  8  FIFO read data; valid the cycle after fifo_ren.
- fifo_error  in  1  FIFO error flag; sampled only the cycle after fifo_ren; 1 = FIFO was empty.
- flush  in  1  single-cycle request to emit any held byte.
- out_valid  out  1  out_data/out_partial valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  16  packed word; first byte in [7:0], second in [15:8].
- out_partial  out  1  1 = only [7:0] valid, [15:8] = 8'h00.

## Operation
- States: FETCH, CAPTURE, SEND. Reset state FETCH.
- Registers: hold[7:0], byte_cnt (0/1), flush_pend, state.
- FETCH:
  - If (flush or flush_pend) and byte_cnt==1: load out_data={8'h00,hold}, out_partial=1, out_valid=1, byte_cnt=0, clear flush_pend, go SEND. fifo_ren=0.
  - Else if (flush or flush_pend) and byte_cnt==0: clear flush_pend; proceed as normal.
  - Normal: fifo_ren=1 (combinational from state), go CAPTURE.
- CAPTURE: fifo_ren=0; sample fifo_error/fifo_dout.
  - fifo_error==1: discard fifo_dout, go FETCH (retry).
  - fifo_error==0, byte_cnt==0: hold<=fifo_dout, byte_cnt<=1, go FETCH.
  - fifo_error==0, byte_cnt==1: out_data<={fifo_dout,hold}, out_partial<=0, out_valid<=1, byte_cnt<=0, go SEND.
- SEND: hold out_data/out_partial stable; on out_valid&&out_ready clear out_valid, go FETCH. fifo_ren=0.
- flush seen in CAPTURE or SEND sets flush_pend; serviced at next FETCH entry against the byte_cnt at that time (a completed full word makes it a no-op).
- fifo_ren never asserted outside FETCH, so the FIFO never sees ren while a word is waiting.

## Timing
- Reset values: fifo_ren=0 during reset, out_valid=0, out_data=16'h0000, out_partial=0; hold=0, byte_cnt=0, flush_pend=0.
- First fifo_ren in the first cycle after rst_n rises.
- Byte read = 2 cycles (FETCH, CAPTURE). Full word with FIFO non-empty: fifo_ren high in cycles 0 and 2, out_valid high from cycle 4.
- Output handshake: out_valid held until accepted; data never changes while out_valid=1 and out_ready=0.
- Flush in FETCH with byte held: out_valid high next cycle, no FIFO read that cycle.
- Reset mid-operation: held byte and any in-flight FIFO byte are dropped; out_valid drops on the reset edge.

## Configuration
- PACKER_TIMEOUT_EN defined: an 8-bit empty counter increments on each CAPTURE with fifo_error==1 while byte_cnt==1. It clears when byte_cnt goes to 0 or on reset. On reaching TIMEOUT it sets flush_pend, so a partial word is emitted at the next FETCH.
- Not defined: counter absent; a held byte leaves only via a second byte or flush. TIMEOUT ignored.

## Structure
- Shared package fifo_pkg: state enum (FETCH, CAPTURE, SEND), BYTE_W=8, WORD_W=16, PARTIAL_PAD=8'h00.
- One sub-module packer_timeout_ctr (count enable, clear, TIMEOUT parameter, expired output), instantiated only under PACKER_TIMEOUT_EN.

## Test plan
- FIFO preloaded with 8'hA1, 8'hB2, out_ready=1 -> out_data=16'hB2A1, out_partial=0, out_valid from cycle 4 after first fifo_ren.
- FIFO holds only 8'h5C, flush pulsed after capture -> out_data=16'h005C, out_partial=1, no extra fifo_ren that cycle.
- Words 16'h2211, 16'h4433 available, out_ready=0 for 10 cycles -> out_data stays 16'h2211, fifo_ren=0 throughout; after ready, 16'h4433 follows.
- FIFO empty -> fifo_ren toggles every other cycle, fifo_error=1 each CAPTURE, out_valid stays 0.
- With PACKER_TIMEOUT_EN and TIMEOUT=4, single byte 8'h7E then empty -> partial 16'h007E emitted after the 4th empty CAPTURE; without the macro, nothing is emitted.
- rst_n low in CAPTURE with hold=8'h11 -> all outputs at reset values; the next word is built from fresh bytes only.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and widths for the FIFO word packer.
package fifo_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  localparam logic [BYTE_W-1:0] PARTIAL_PAD = 8'h00;

  typedef logic [1:0] state_t;

  localparam state_t FETCH   = 2'd0;
  localparam state_t CAPTURE = 2'd1;
  localparam state_t SEND    = 2'd2;

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port, flush request and packed-word valid/ready port of the packer.
interface fifo_word_packer_if;
  import fifo_pkg::*;

  logic              fifo_ren;
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_error;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_partial;

  modport master (
    output fifo_ren, out_valid, out_data, out_partial,
    input  fifo_dout, fifo_error, flush, out_ready
  );

  modport slave (
    input  fifo_ren, out_valid, out_data, out_partial,
    output fifo_dout, fifo_error, flush, out_ready
  );

endinterface

// File: rtl/packer_timeout_ctr.sv
// Counts consecutive empty reads while a byte is held; flags the read that reaches TIMEOUT.
module packer_timeout_ctr
  import fifo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cnt_en,
  input  logic clr,
  output logic expired
);

  logic [BYTE_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_q <= '0;
    end else if (cnt_en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Fires on the increment that lands on TIMEOUT so the flush is pending at the next FETCH.
  assign expired = cnt_en && !clr && (cnt_q == BYTE_W'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_word_packer.sv
// Reads bytes from the FIFO and packs pairs into 16-bit words on a valid/ready port.
// Define PACKER_TIMEOUT_EN to auto-flush a held byte after TIMEOUT empty reads.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_word_packer_if.master bus
);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              byte_cnt_q, byte_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_partial_q, out_partial_d;
  logic              ren;
  logic              flush_req;
  logic              tmo_expired;

`ifdef PACKER_TIMEOUT_EN
  packer_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_en  ((state_q == CAPTURE) && bus.fifo_error && byte_cnt_q),
    .clr     (!byte_cnt_q),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_expired    = 1'b0;
`endif

  assign flush_req = bus.flush || flush_pend_q;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    byte_cnt_d    = byte_cnt_q;
    flush_pend_d  = flush_pend_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_partial_d = out_partial_q;
    ren           = 1'b0;
    case (state_q)
      FETCH: begin
        flush_pend_d = 1'b0;
        if (flush_req && byte_cnt_q) begin
          out_data_d    = {PARTIAL_PAD, hold_q};
          out_partial_d = 1'b1;
          out_valid_d   = 1'b1;
          byte_cnt_d    = 1'b0;
          state_d       = SEND;
        end else begin
          ren     = 1'b1;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.flush || tmo_expired) flush_pend_d = 1'b1;
        state_d = FETCH;
        if (!bus.fifo_error) begin
          if (!byte_cnt_q) begin
            hold_d     = bus.fifo_dout;
            byte_cnt_d = 1'b1;
          end else begin
            out_data_d    = {bus.fifo_dout, hold_q};
            out_partial_d = 1'b0;
            out_valid_d   = 1'b1;
            byte_cnt_d    = 1'b0;
            state_d       = SEND;
          end
        end
      end
      SEND: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      hold_q        <= '0;
      byte_cnt_q    <= 1'b0;
      flush_pend_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_partial_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      byte_cnt_q    <= byte_cnt_d;
      flush_pend_q  <= flush_pend_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_partial_q <= out_partial_d;
    end
  end

  // State is unknown before the first reset edge, so the read request is gated by reset.
  assign bus.fifo_ren    = ren & rst_n;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_partial = out_partial_q;

endmodule
